// File: rtl/dpm_pkg.sv
// dpm_pkg: shared types for the dual-port memory initiator.
//   dpm_op_e          command operation encoding (CLEAR/READ/WRITE/RDWR)
//   dpm_init_state_e  initiator FSM states
//   OP_*_ENC          raw 2-bit operation codes as seen on cmd_op
//   op_we / op_re     memory strobes implied by an operation
package dpm_pkg;

  localparam logic [1:0] OP_CLEAR_ENC = 2'b00;
  localparam logic [1:0] OP_READ_ENC  = 2'b01;
  localparam logic [1:0] OP_WRITE_ENC = 2'b10;
  localparam logic [1:0] OP_RDWR_ENC  = 2'b11;

  typedef enum logic [1:0] {
    OP_CLEAR = OP_CLEAR_ENC,
    OP_READ  = OP_READ_ENC,
    OP_WRITE = OP_WRITE_ENC,
    OP_RDWR  = OP_RDWR_ENC
  } dpm_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } dpm_init_state_e;

  // The encoding is chosen so bit 1 is the write strobe and bit 0 the read
  // strobe; CLEAR is the only code with both strobes low.
  function automatic logic op_we(input dpm_op_e op);
    return op[1];
  endfunction

  function automatic logic op_re(input dpm_op_e op);
    return op[0];
  endfunction

endpackage

// File: rtl/dpm_watchdog.sv
// dpm_watchdog: wait-cycle counter for one memory beat.
//   clk, rst  clock and synchronous active-low reset
//   start     clears the count (asserted the cycle before WAIT is entered)
//   tick      one more cycle spent waiting without mem_ready
//   expired   high on the tick that brings the count to LIMIT
module dpm_watchdog #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic tick,
  output logic expired
);

  // The count only has to represent 0..LIMIT-1; the LIMIT-th tick is the
  // one that raises expired, so it is never stored.
  localparam int CW = (LIMIT < 2) ? 1 : $clog2(LIMIT);

  logic [CW-1:0] count;

  assign expired = tick && (count == CW'(LIMIT - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (start) begin
      count <= '0;
    end else if (tick && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/dp_mem_initiator.sv
// dp_mem_initiator: turns commands into single-beat or burst accesses on the
// dual-port memory request port and returns one response per beat.
//
// Ports
//   clk, rst                 clock, synchronous active-low reset
//   cmd_valid/cmd_ready      command channel; cmd_ready is high only in IDLE
//   cmd_op                   00 CLEAR, 01 READ, 10 WRITE, 11 RDWR
//   cmd_addr/cmd_raddr       start write address (and READ address) / RDWR read address
//   cmd_len                  beats minus one (ignored for CLEAR)
//   cmd_wdata                write data of beat 0; beat k writes cmd_wdata+k
//   rsp_valid/rsp_ready      response channel, one response per beat
//   rsp_data/rsp_last/rsp_err  read data (0 unless the beat read), final beat, timeout
//   mem_*                    memory request strobes, addresses, data and acknowledge
//   busy                     high whenever the FSM is not in IDLE
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid never waits for ready and a held response stays stable
// until it is taken.
//
// Build option: define DPM_INIT_TIMEOUT_EN to bound the wait for mem_ready
// by TIMEOUT_CYCLES; a timed-out beat ends the command with rsp_err=1.
//
// The FSM state is kept in the signal `state` for bound checkers.
module dp_mem_initiator
  import dpm_pkg::*;
#(
  parameter int DATA_SIZE      = 32,
  parameter int ADDR_WIDTH     = 4,
  parameter int LEN_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH-1:0] cmd_raddr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [DATA_SIZE-1:0]  cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_SIZE-1:0]  rsp_data,
  output logic                  rsp_last,
  output logic                  rsp_err,
  output logic                  mem_valid,
  output logic                  mem_we,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_w_addr,
  output logic [ADDR_WIDTH-1:0] mem_r_addr,
  output logic [DATA_SIZE-1:0]  mem_w_data,
  input  logic [DATA_SIZE-1:0]  mem_r_data,
  input  logic                  mem_ready,
  output logic                  busy
);

  dpm_init_state_e       state;
  dpm_op_e               op_q;
  dpm_op_e               cmd_op_e;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [ADDR_WIDTH-1:0] raddr_q;   // effective read base (cmd_raddr only for RDWR)
  logic [DATA_SIZE-1:0]  wdata_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  k;
  logic [LEN_WIDTH-1:0]  k_next;

  assign cmd_op_e = dpm_op_e'(cmd_op);
  assign k_next   = k + 1'b1;

`ifdef DPM_INIT_TIMEOUT_EN
  logic wd_expired;

  dpm_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .start   (state == ST_ISSUE),
    .tick    ((state == ST_WAIT) && !mem_ready),
    .expired (wd_expired)
  );
`else
  assign rsp_err = 1'b0;
`endif

  // The memory request is registered on the edge that enters ISSUE, so the
  // strobes are visible for exactly the one ISSUE cycle and drop on the edge
  // into WAIT. Addresses and data are left holding their last values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      op_q       <= OP_CLEAR;
      waddr_q    <= '0;
      raddr_q    <= '0;
      wdata_q    <= '0;
      len_q      <= '0;
      k          <= '0;
      cmd_ready  <= 1'b1;
      busy       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_last   <= 1'b0;
      mem_valid  <= 1'b0;
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
      mem_w_addr <= '0;
      mem_r_addr <= '0;
      mem_w_data <= '0;
`ifdef DPM_INIT_TIMEOUT_EN
      rsp_err    <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q       <= cmd_op_e;
            waddr_q    <= cmd_addr;
            raddr_q    <= (cmd_op_e == OP_RDWR) ? cmd_raddr : cmd_addr;
            wdata_q    <= cmd_wdata;
            len_q      <= (cmd_op_e == OP_CLEAR) ? '0 : cmd_len;
            k          <= '0;
            mem_valid  <= 1'b1;
            mem_we     <= op_we(cmd_op_e);
            mem_re     <= op_re(cmd_op_e);
            mem_w_addr <= cmd_addr;
            mem_r_addr <= (cmd_op_e == OP_RDWR) ? cmd_raddr : cmd_addr;
            mem_w_data <= cmd_wdata;
            cmd_ready  <= 1'b0;
            busy       <= 1'b1;
            state      <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          mem_valid <= 1'b0;
          mem_we    <= 1'b0;
          mem_re    <= 1'b0;
          state     <= ST_WAIT;
        end

        ST_WAIT: begin
          if (mem_ready) begin
            rsp_valid <= 1'b1;
            rsp_data  <= op_re(op_q) ? mem_r_data : '0;
            rsp_last  <= (k == len_q);
`ifdef DPM_INIT_TIMEOUT_EN
            rsp_err   <= 1'b0;
`endif
            state     <= ST_RESP;
          end
`ifdef DPM_INIT_TIMEOUT_EN
          else if (wd_expired) begin
            // Marking the beat last makes the handshake return to IDLE,
            // which drops the rest of the burst.
            rsp_valid <= 1'b1;
            rsp_data  <= '0;
            rsp_last  <= 1'b1;
            rsp_err   <= 1'b1;
            state     <= ST_RESP;
          end
`endif
        end

        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (rsp_last) begin
              cmd_ready <= 1'b1;
              busy      <= 1'b0;
              state     <= ST_IDLE;
            end else begin
              k          <= k_next;
              mem_valid  <= 1'b1;
              mem_we     <= op_we(op_q);
              mem_re     <= op_re(op_q);
              mem_w_addr <= waddr_q + ADDR_WIDTH'(k_next);
              mem_r_addr <= raddr_q + ADDR_WIDTH'(k_next);
              mem_w_data <= wdata_q + DATA_SIZE'(k_next);
              state      <= ST_ISSUE;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/dp_mem_initiator.md
# dp_mem_initiator

Bus initiator that drives the valid/we/re/ready port of the team's dual-port memory. It converts commands from a command channel into single-beat or burst memory accesses, then returns one response per beat on a response channel. It sits between test sequencers or DMA-style clients and `dp_memory`. It guarantees that the memory's "clear-all" encoding (valid with we=0, re=0) is only ever issued by an explicit CLEAR command.

## Interface
Parameters:
- DATA_SIZE, 32, data width; matches the memory.
- ADDR_WIDTH, 4, address width; the memory depth is 2**ADDR_WIDTH.
- LEN_WIDTH, 4, width of the burst length field; a burst is cmd_len+1 beats.
- TIMEOUT_CYCLES, 15, maximum wait cycles for mem_ready; used only with the timeout feature.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted; high only in IDLE.
- cmd_op  in  2  operation: 00 CLEAR, 01 READ, 10 WRITE, 11 RDWR.
- cmd_addr  in  ADDR_WIDTH  start write address; also the start read address for READ.
- cmd_raddr  in  ADDR_WIDTH  start read address for RDWR.
- cmd_len  in  LEN_WIDTH  number of beats minus one.
- cmd_wdata  in  DATA_SIZE  write data for beat 0.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_data  out  DATA_SIZE  read data; 0 for WRITE and CLEAR.
- rsp_last  out  1  final beat of the command.
- rsp_err  out  1  beat timed out.
- mem_valid, mem_we, mem_re  out  1 each  memory request strobes.
- mem_w_addr, mem_r_addr  out  ADDR_WIDTH  memory addresses.
- mem_w_data  out  DATA_SIZE  memory write data.
- mem_r_data  in  DATA_SIZE  memory read data.
- mem_ready  in  1  memory acknowledge.
- busy  out  1  high in any state other than IDLE.

## Operation
- The FSM states are IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - cmd_ready=1.
  - On cmd_valid, latch op, addresses, wdata and len; clear the beat counter k; go to ISSUE.
  - CLEAR forces len=0.
- **ISSUE** (exactly one cycle):
  - mem_valid=1.
  - we/re by op: CLEAR 0/0, READ 0/1, WRITE 1/0, RDWR 1/1.
  - mem_w_addr=cmd_addr+k and mem_r_addr=(RDWR ? cmd_raddr : cmd_addr)+k, both modulo 2**ADDR_WIDTH (wrap-around, no error).
  - mem_w_data=cmd_wdata+k, modulo 2**DATA_SIZE.
  - Go to WAIT.
- **WAIT:**
  - mem_valid=0, we=0, re=0; addresses and data hold their values.
  - When mem_ready=1, register rsp_data (mem_r_data if re was set for the beat, else 0), rsp_last=(k==len) and rsp_err=0; go to RESP.
- **RESP:**
  - rsp_valid=1; the response is held stable until rsp_ready.
  - On the handshake, go to IDLE if last; otherwise k++ and go to ISSUE.
- The initiator never drives mem_valid with we=re=0 except for CLEAR.
- **Reset:**
  - All outputs are 0, except cmd_ready=1.
  - State is IDLE; k and the latched command are cleared.
  - Reset mid-burst abandons the burst. No response is produced for it.

## Timing
- A command is accepted at edge T0.
- mem_valid is high during cycle T0+1.
- mem_ready is sampled during T0+2.
- With a 1-cycle memory, rsp_valid rises at T0+3.
- Each further beat costs 3 cycles plus the rsp_ready stall.
- cmd_ready and rsp_valid are never high in the same cycle.
- rsp_valid, rsp_data, rsp_last and rsp_err are registered outputs. mem_* are registered outputs.

## Configuration
- **`DPM_INIT_TIMEOUT_EN` defined:**
  - WAIT counts cycles with mem_ready=0.
  - When the count reaches TIMEOUT_CYCLES, go to RESP with rsp_err=1, rsp_last=1 and rsp_data=0.
  - The remaining beats are dropped.
  - The counter is cleared on each entry to WAIT.
- **Not defined:**
  - WAIT waits indefinitely.
  - rsp_err is tied to 0.
  - No counter is synthesised.

## Structure
- Package `dpm_pkg`:
  - enum `dpm_op_e` (CLEAR/READ/WRITE/RDWR).
  - enum `dpm_init_state_e`.
  - Op encoding constants.
- Sub-module `dpm_watchdog`:
  - Contents: the timeout counter, with inputs start/tick and output expired.
  - Instantiated only under `DPM_INIT_TIMEOUT_EN`.

## Test plan
- **Single write then read:** WRITE addr 3, wdata 0xDEADBEEF, len 0, followed by READ addr 3 → one rsp with last=1 and data 0; then rsp_data=0xDEADBEEF.
- **Write burst with wrap:** WRITE addr 14, len 3, wdata 0x10 writes mem[14]=0x10, mem[15]=0x11, mem[0]=0x12, mem[1]=0x13. A READ of that range returns the same values with rsp_last only on beat 4.
- **RDWR:** after mem[5]=0xA5, RDWR with cmd_addr 2, cmd_raddr 5, wdata 0x77 → rsp_data=0xA5 and mem[2]=0x77.
- **Backpressure:** rsp_ready held low 6 cycles in a READ burst → rsp_data stable, no new mem_valid until the handshake.
- **CLEAR:** CLEAR with len 7 → exactly one mem_valid pulse with we=re=0, one rsp with last=1, and all locations read back 0.
- **Timeout and reset:** with `DPM_INIT_TIMEOUT_EN`, memory held in reset so ready stays 0 → after 15 WAIT cycles rsp_err=1 and rsp_last=1. Separately, rst asserted mid-burst → next cycle busy=0, cmd_ready=1, no rsp.
